// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared state, requester and data-width definitions for the register-bus arbiter
package reg_bus_pkg;

    localparam int REG_DATA_W = 8;

    localparam logic REQ_HOST  = 1'b0;
    localparam logic REQ_MAPLE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/reg_bus_rr_pick.sv
// rtl/reg_bus_rr_pick.sv - combinational two-way round-robin selector
module reg_bus_rr_pick
    import reg_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       grant,
    output logic       valid
);

    // A lone requester always wins; the pointer only breaks ties.
    assign valid = |req;
    assign grant = (&req) ? ptr : req[REQ_MAPLE];

endmodule

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - two-requester arbiter and sequencer for the shared control-register bus
// Optional bus locking is enabled by defining REG_ARB_LOCK_EN.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [REG_DATA_W-1:0] wdata0,
    input  logic [REG_DATA_W-1:0] wdata1,
`ifdef REG_ARB_LOCK_EN
    input  logic [1:0]            lock,
`endif
    output logic [1:0]            ack,
    output logic [REG_DATA_W-1:0] rdata,
    output logic                  busy,
    output logic [NUM_REGS-1:0]   reg_cs,
    output logic                  reg_we,
    output logic [REG_DATA_W-1:0] reg_wdata,
    input  logic [REG_DATA_W-1:0] reg_rdata
);

    arb_state_t              state;
    logic                    ptr;
    logic                    grant;
    logic                    ptr_next;
    logic                    pick_grant;
    logic                    pick_valid;
    logic [ADDR_W-1:0]       pick_addr;
    logic                    pick_we;
    logic [REG_DATA_W-1:0]   pick_wdata;
    logic [NUM_REGS-1:0]     pick_cs;

    reg_bus_rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // Out-of-range addresses match no bit, so they decode to an all-zero select.
    always_comb begin
        pick_addr  = pick_grant ? addr1  : addr0;
        pick_we    = pick_grant ? we1    : we0;
        pick_wdata = pick_grant ? wdata1 : wdata0;
        pick_cs    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pick_cs[i] = (pick_addr == ADDR_W'(i));
        end
    end

`ifdef REG_ARB_LOCK_EN
    assign ptr_next = lock[grant] ? grant : ~grant;
`else
    assign ptr_next = ~grant;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= REQ_HOST;
            grant     <= REQ_HOST;
            ack       <= 2'b00;
            rdata     <= '0;
            busy      <= 1'b0;
            reg_cs    <= '0;
            reg_we    <= 1'b0;
            reg_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= ACCESS;
                        busy      <= 1'b1;
                        grant     <= pick_grant;
                        reg_cs    <= pick_cs;
                        reg_we    <= pick_we;
                        reg_wdata <= pick_wdata;
                    end
                end
                ACCESS: begin
                    state <= DONE;
                    if (!reg_we) begin
                        rdata <= (|reg_cs) ? reg_rdata : '0;
                    end
                    reg_cs <= '0;
                    reg_we <= 1'b0;
                    ack    <= grant ? 2'b10 : 2'b01;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ack   <= 2'b00;
                    ptr   <= ptr_next;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - directed scoreboard bench for reg_bus_arbiter (NUM_REGS=4)
`timescale 1ns/1ps
module tb_reg_bus_arbiter;

    localparam int NR = 4;

    typedef struct packed {
        logic [1:0] ack;
        logic [7:0] rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic [2:0] addr0 = '0, addr1 = '0;
    logic       we0 = 1'b0, we1 = 1'b0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
`ifdef REG_ARB_LOCK_EN
    logic [1:0] lock = 2'b00;
`endif
    logic [1:0]    ack;
    logic [7:0]    rdata;
    logic          busy;
    logic [NR-1:0] reg_cs;
    logic          reg_we;
    logic [7:0]    reg_wdata;
    logic [7:0]    reg_rdata;

    logic [7:0] bank [NR] = '{default: 8'h00};
    exp_t       sb [$];
    int         checks = 0;
    int         errors = 0;

    reg_bus_arbiter #(.NUM_REGS(NR), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr0     (addr0),
        .addr1     (addr1),
        .we0       (we0),
        .we1       (we1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
`ifdef REG_ARB_LOCK_EN
        .lock      (lock),
`endif
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .reg_cs    (reg_cs),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        reg_rdata = 8'h00;
        for (int i = 0; i < NR; i++) begin
            if (reg_cs[i]) reg_rdata = reg_rdata | bank[i];
        end
    end

    always @(posedge clk) begin
        if (reg_we) begin
            for (int i = 0; i < NR; i++) begin
                if (reg_cs[i]) bank[i] <= reg_wdata;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && ack !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_owner", {30'd0, ack}, {30'd0, e.ack});
                chk("ack_rdata", {24'd0, rdata}, {24'd0, e.rdata});
            end
        end
    end

    task automatic single(input logic idx, input logic [2:0] a, input logic w,
                          input logic [7:0] d, input logic [NR-1:0] exp_cs,
                          input logic [7:0] exp_rd);
        @(negedge clk);
        if (idx) begin
            addr1 = a; we1 = w; wdata1 = d; req[1] = 1'b1;
        end else begin
            addr0 = a; we0 = w; wdata0 = d; req[0] = 1'b1;
        end
        sb.push_back('{ack: (idx ? 2'b10 : 2'b01), rdata: exp_rd});
        @(negedge clk);
        chk("access_cs", {28'd0, reg_cs}, {28'd0, exp_cs});
        chk("access_we", {31'd0, reg_we}, {31'd0, w});
        chk("access_busy", {31'd0, busy}, 32'd1);
        if (w) chk("access_wdata", {24'd0, reg_wdata}, {24'd0, d});
        @(negedge clk);
        chk("done_cs", {28'd0, reg_cs}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd1);
        req = 2'b00;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ack", {30'd0, ack}, 32'd0);
        chk("ack_arrived", sb.size(), 32'd0);
    endtask

    initial begin
        int n;
        int at;

        repeat (3) @(negedge clk);
        chk("rst_ack", {30'd0, ack}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cs", {28'd0, reg_cs}, 32'd0);
        chk("rst_we", {31'd0, reg_we}, 32'd0);
        chk("rst_wdata", {24'd0, reg_wdata}, 32'd0);
        rst = 1'b1;

        single(1'b0, 3'd2, 1'b1, 8'hA5, 4'b0100, 8'h00);
        chk("bank2_written", {24'd0, bank[2]}, 32'hA5);
        single(1'b1, 3'd2, 1'b0, 8'h00, 4'b0100, 8'hA5);
        single(1'b0, 3'd1, 1'b1, 8'h5A, 4'b0010, 8'hA5);
        chk("bank1_written", {24'd0, bank[1]}, 32'h5A);
        single(1'b1, 3'd5, 1'b0, 8'h00, 4'b0000, 8'h00);
        single(1'b0, 3'd7, 1'b1, 8'hFF, 4'b0000, 8'h00);
        chk("oor_bank0", {24'd0, bank[0]}, 32'h00);
        chk("oor_bank1", {24'd0, bank[1]}, 32'h5A);
        chk("oor_bank2", {24'd0, bank[2]}, 32'hA5);
        chk("oor_bank3", {24'd0, bank[3]}, 32'h00);
        single(1'b1, 3'd2, 1'b1, 8'h3C, 4'b0100, 8'h00);
        single(1'b0, 3'd2, 1'b0, 8'h00, 4'b0100, 8'h3C);

        // Reset mid-ACCESS: the write to reg 1 must not land.
        @(negedge clk);
        addr0 = 3'd1; we0 = 1'b1; wdata0 = 8'hEE; req = 2'b01;
        @(negedge clk);
        chk("mid_cs_before", {28'd0, reg_cs}, 32'b0010);
        #2 rst = 1'b0;
        #1;
        chk("mid_cs_after", {28'd0, reg_cs}, 32'd0);
        chk("mid_busy_after", {31'd0, busy}, 32'd0);
        chk("mid_ack_after", {30'd0, ack}, 32'd0);
        chk("mid_we_after", {31'd0, reg_we}, 32'd0);
        req = 2'b00;
        @(negedge clk);
        chk("mid_bank1_kept", {24'd0, bank[1]}, 32'h5A);
        chk("mid_rdata_reset", {24'd0, rdata}, 32'd0);
        rst = 1'b1;

        // Both requesting: grants alternate from requester 0, one access every 3 cycles.
        @(negedge clk);
        addr0 = 3'd3; we0 = 1'b1; wdata0 = 8'h11;
        addr1 = 3'd2; we1 = 1'b0;
        req = 2'b11;
        sb.push_back('{ack: 2'b01, rdata: 8'h00});
        sb.push_back('{ack: 2'b10, rdata: 8'h3C});
        sb.push_back('{ack: 2'b01, rdata: 8'h3C});
        sb.push_back('{ack: 2'b10, rdata: 8'h3C});
        n = 0;
        at = 0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(negedge clk);
            if (ack !== 2'b00) begin
                n++;
                if (n == 4) begin
                    req = 2'b00;
                    at = c;
                end
            end
        end
        chk("rr_ack_count", n, 32'd4);
        chk("rr_throughput", at, 32'd11);
        repeat (2) @(negedge clk);
        chk("rr_sb_empty", sb.size(), 32'd0);
        chk("rr_bank3", {24'd0, bank[3]}, 32'h11);

`ifdef REG_ARB_LOCK_EN
        @(negedge clk);
        addr0 = 3'd0; we0 = 1'b0;
        addr1 = 3'd3; we1 = 1'b0;
        lock = 2'b01;
        req = 2'b11;
        sb.push_back('{ack: 2'b01, rdata: 8'h00});
        sb.push_back('{ack: 2'b01, rdata: 8'h00});
        sb.push_back('{ack: 2'b01, rdata: 8'h00});
        sb.push_back('{ack: 2'b10, rdata: 8'h11});
        n = 0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(negedge clk);
            if (ack !== 2'b00) begin
                n++;
                if (n == 3) lock = 2'b00;
                if (n == 4) req = 2'b00;
            end
        end
        chk("lock_ack_count", n, 32'd4);
        repeat (2) @(negedge clk);
        chk("lock_sb_empty", sb.size(), 32'd0);
`endif

        repeat (2) @(negedge clk);
        chk("final_sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
